frame_hdr_rx: RTL and testbench
===============================

FRAME_HDR_RX -- requirements
Module: frame_hdr_rx

Interface
REQ-001 Parameter SYNC_WORD, default 32'h1ACFFC1D: frame sync pattern, compared MSB (oldest bit) first.
REQ-002 Parameter MAX_SYNC_ERR, default 2: maximum Hamming distance accepted as a sync match.
REQ-003 Parameter MAX_FRAME_BITS, default 16'd60000: payload timeout, counted in in_valid beats.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_bit  in  1  demodulated hard bit.
REQ-007 in_valid  in  1  in_bit qualifier; when low the block stalls, except for eof_rx handling.
REQ-008 eof_rx  in  1  end-of-frame pulse from the payload path.
REQ-009 sof_rx  out  1  one-cycle pulse when a valid header is accepted.
REQ-010 oindex_M, oindex_SS, oindex_BW, oindex_data_off  out  3/4/3/1  parameters from the last valid header.
REQ-011 locked  out  1  high while in PAYLOAD.
REQ-012 hdr_err  out  1  one-cycle pulse when a header is rejected.
REQ-013 timeout_err  out  1  one-cycle pulse when the payload timeout fires.

Function
REQ-014 The FSM SHALL have states SEARCH, HEADER and PAYLOAD.
REQ-015 In SEARCH, each in_valid beat SHALL shift in_bit into a 32-bit shift register at the LSB and increment a fill counter, saturating at 32.
REQ-016 A sync match SHALL be declared when fill==32 and popcount(shreg XOR SYNC_WORD) <= MAX_SYNC_ERR, both evaluated on the register value including the current beat.
- On a match: go to HEADER; clear the header bit counter.
REQ-017 In HEADER, the block SHALL capture 16 bits, MSB first, on in_valid beats.
- Header layout: [15:13] M, [12:9] SS, [8:6] BW, [5] data_off, [4:0] CRC.
REQ-018 CRC SHALL be CRC-5, polynomial x^5+x^2+1, init 5'b00000, computed serially over header bits 15..5, no reflection, no final XOR.
REQ-019 A header SHALL be valid iff the computed CRC equals the received bits [4:0], M != 0 and SS != 0.
REQ-020 On the 16th header beat with a valid header, the block SHALL do all of the following in the next cycle:
- pulse sof_rx;
- load all oindex_* outputs;
- enter PAYLOAD with locked=1.
REQ-021 On the 16th header beat with an invalid header, the block SHALL pulse hdr_err in the next cycle, return to SEARCH and leave oindex_* unchanged.
REQ-022 On entry to SEARCH from any state, the shift register and fill counter SHALL be cleared, so a new sync needs 32 fresh bits.
REQ-023 In PAYLOAD, a 16-bit counter SHALL count in_valid beats.
- eof_rx: go to SEARCH next cycle.
- Counter reaches MAX_FRAME_BITS-1 on a valid beat: pulse timeout_err and go to SEARCH.
REQ-024 If eof_rx and the timeout occur in the same cycle, the block SHALL go to SEARCH and SHALL NOT pulse timeout_err.
REQ-025 eof_rx SHALL be ignored in SEARCH and HEADER.
REQ-026 oindex_* SHALL change only at sof_rx and hold otherwise, including after locked falls.
REQ-027 Sync detection SHALL be inactive in HEADER and PAYLOAD; a sync pattern inside the payload has no effect.

Reset
REQ-028 While rst is high, the block SHALL be in SEARCH, and all of the following SHALL be cleared: shift register, fill counter, header counter and payload counter.
REQ-029 Reset output values SHALL be: sof_rx=0, hdr_err=0, timeout_err=0, locked=0, oindex_M=3'd1, oindex_SS=4'd1, oindex_BW=3'd0, oindex_data_off=0.
REQ-030 Reset asserted mid-HEADER or mid-PAYLOAD SHALL discard the partial frame with no sof_rx, hdr_err or timeout_err pulse.

Verification
REQ-031 Clean frame: SYNC_WORD followed by header 16'h4850 -> one sof_rx pulse one cycle after the last header beat; M=2, SS=4, BW=1, data_off=0; locked=1.
REQ-032 Corrupted CRC: SYNC_WORD + 16'h4851 -> hdr_err pulse; oindex_* stay at reset values; locked=0; the next clean frame is accepted.
REQ-033 Sync errors: SYNC_WORD with 2 bits flipped + 16'h4850 -> accepted; with 3 bits flipped -> no HEADER entry, no pulses.
REQ-034 Stalls: random in_valid gaps during sync and header -> same result as REQ-031; sof_rx is asserted exactly once.
REQ-035 Timeout and EOF: with MAX_FRAME_BITS=100 and no eof_rx -> timeout_err on beat 100 of the payload.
- With eof_rx on that same beat -> SEARCH and no timeout_err.
- SYNC_WORD inside the payload -> ignored.
REQ-036 Reset mid-header: rst after 8 header bits -> no pulses; outputs at reset values; fill counter restarts from 0.

Source files
------------

// File: rtl/frame_hdr_rx.sv
// Frame header receiver: sync-word search with Hamming tolerance, CRC-5 protected
// 16-bit header capture, and payload supervision with an end-of-frame or beat-count timeout.
module frame_hdr_rx #(
  parameter logic [31:0] SYNC_WORD      = 32'h1ACFFC1D,
  parameter int          MAX_SYNC_ERR   = 2,
  parameter logic [15:0] MAX_FRAME_BITS = 16'd60000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_bit,
  input  logic       in_valid,
  input  logic       eof_rx,
  output logic       sof_rx,
  output logic [2:0] oindex_M,
  output logic [3:0] oindex_SS,
  output logic [2:0] oindex_BW,
  output logic       oindex_data_off,
  output logic       locked,
  output logic       hdr_err,
  output logic       timeout_err
);

  // state | meaning
  // SEARCH  | hunting for the sync word
  // HEADER  | capturing the 16-bit header
  // PAYLOAD | locked, counting payload beats until eof or timeout
  localparam logic [1:0] ST_SEARCH  = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [5:0]  fill_q, fill_d;
  logic [3:0]  hcnt_q, hcnt_d;
  logic [14:0] hdr_q, hdr_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        sof_q, sof_d;
  logic        herr_q, herr_d;
  logic        to_q, to_d;
  logic [2:0]  m_q, m_d;
  logic [3:0]  ss_q, ss_d;
  logic [2:0]  bw_q, bw_d;
  logic        doff_q, doff_d;

  logic [31:0] shreg_nx;
  logic [5:0]  fill_nx;
  logic        sync_hit;
  logic [15:0] hdr_full;
  logic        hdr_ok;

  function automatic logic [4:0] crc5(input logic [10:0] d);
    logic [4:0] c;
    logic       fb;
    c = 5'b00000;
    for (int i = 10; i >= 0; i--) begin
      fb = d[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return c;
  endfunction

  // Match is judged on the window that already includes the current bit.
  assign shreg_nx = {shreg_q[30:0], in_bit};
  assign fill_nx  = (fill_q == 6'd32) ? 6'd32 : fill_q + 6'd1;
  assign sync_hit = (fill_nx == 6'd32) && ($countones(shreg_nx ^ SYNC_WORD) <= MAX_SYNC_ERR);
  assign hdr_full = {hdr_q, in_bit};
  assign hdr_ok   = (crc5(hdr_full[15:5]) == hdr_full[4:0]) && (|hdr_full[15:13]) && (|hdr_full[12:9]);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    fill_d  = fill_q;
    hcnt_d  = hcnt_q;
    hdr_d   = hdr_q;
    pcnt_d  = pcnt_q;
    sof_d   = 1'b0;
    herr_d  = 1'b0;
    to_d    = 1'b0;
    m_d     = m_q;
    ss_d    = ss_q;
    bw_d    = bw_q;
    doff_d  = doff_q;
    case (state_q)
      ST_SEARCH: begin
        if (in_valid) begin
          if (sync_hit) begin
            // Search registers leave zeroed so the next return to SEARCH starts fresh.
            state_d = ST_HEADER;
            hcnt_d  = 4'd0;
            shreg_d = '0;
            fill_d  = '0;
          end else begin
            shreg_d = shreg_nx;
            fill_d  = fill_nx;
          end
        end
      end
      ST_HEADER: begin
        if (in_valid) begin
          hdr_d  = hdr_full[14:0];
          hcnt_d = hcnt_q + 4'd1;
          if (hcnt_q == 4'd15) begin
            pcnt_d = '0;
            if (hdr_ok) begin
              state_d = ST_PAYLOAD;
              sof_d   = 1'b1;
              m_d     = hdr_full[15:13];
              ss_d    = hdr_full[12:9];
              bw_d    = hdr_full[8:6];
              doff_d  = hdr_full[5];
            end else begin
              state_d = ST_SEARCH;
              herr_d  = 1'b1;
            end
          end
        end
      end
      ST_PAYLOAD: begin
        // eof wins over a coincident timeout and suppresses its pulse.
        if (eof_rx) begin
          state_d = ST_SEARCH;
          pcnt_d  = '0;
        end else if (in_valid) begin
          if (pcnt_q == MAX_FRAME_BITS - 16'd1) begin
            state_d = ST_SEARCH;
            to_d    = 1'b1;
            pcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + 16'd1;
          end
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SEARCH;
      shreg_q <= '0;
      fill_q  <= '0;
      hcnt_q  <= '0;
      hdr_q   <= '0;
      pcnt_q  <= '0;
      sof_q   <= 1'b0;
      herr_q  <= 1'b0;
      to_q    <= 1'b0;
      m_q     <= 3'd1;
      ss_q    <= 4'd1;
      bw_q    <= 3'd0;
      doff_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
      hcnt_q  <= hcnt_d;
      hdr_q   <= hdr_d;
      pcnt_q  <= pcnt_d;
      sof_q   <= sof_d;
      herr_q  <= herr_d;
      to_q    <= to_d;
      m_q     <= m_d;
      ss_q    <= ss_d;
      bw_q    <= bw_d;
      doff_q  <= doff_d;
    end
  end

  assign sof_rx          = sof_q;
  assign hdr_err         = herr_q;
  assign timeout_err     = to_q;
  assign locked          = (state_q == ST_PAYLOAD);
  assign oindex_M        = m_q;
  assign oindex_SS       = ss_q;
  assign oindex_BW       = bw_q;
  assign oindex_data_off = doff_q;

endmodule

// File: tb/tb_frame_hdr_rx.sv
// Randomized self-checking bench for frame_hdr_rx; expectations come from frame-level
// rules (CRC by polynomial division, Hamming distance of the injected sync errors).
module tb_frame_hdr_rx;

  localparam logic [31:0] SYNC = 32'h1ACFFC1D;
  localparam int          MAXF = 100;

  logic       clk = 1'b0;
  logic       rst, in_bit, in_valid, eof_rx;
  logic       sof_rx, oindex_data_off, locked, hdr_err, timeout_err;
  logic [2:0] oindex_M, oindex_BW;
  logic [3:0] oindex_SS;

  int checks   = 0;
  int failures = 0;
  int sof_n = 0, herr_n = 0, to_n = 0;
  int e_m = 1, e_ss = 1, e_bw = 0, e_doff = 0;

  frame_hdr_rx #(
    .SYNC_WORD     (SYNC),
    .MAX_SYNC_ERR  (2),
    .MAX_FRAME_BITS(16'(MAXF))
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_bit         (in_bit),
    .in_valid       (in_valid),
    .eof_rx         (eof_rx),
    .sof_rx         (sof_rx),
    .oindex_M       (oindex_M),
    .oindex_SS      (oindex_SS),
    .oindex_BW      (oindex_BW),
    .oindex_data_off(oindex_data_off),
    .locked         (locked),
    .hdr_err        (hdr_err),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (sof_rx) sof_n++;
    if (hdr_err) herr_n++;
    if (timeout_err) to_n++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] crc5_ref(input logic [10:0] msg);
    logic [15:0] r;
    r = {msg, 5'b00000};
    for (int i = 15; i >= 5; i--)
      if (r[i]) r = r ^ (16'b100101 << (i - 5));
    return r[4:0];
  endfunction

  function automatic bit hdr_valid_ref(input logic [15:0] h);
    return (crc5_ref(h[15:5]) == h[4:0]) && (h[15:13] != 0) && (h[12:9] != 0);
  endfunction

  task automatic idle(input int n);
    in_valid = 1'b0;
    eof_rx   = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int stall_pct, input bit noise_eof);
    while (int'($urandom_range(99)) < stall_pct) begin
      in_valid = 1'b0;
      eof_rx   = noise_eof && ($urandom_range(3) == 0);
      @(posedge clk);
      #1;
    end
    in_bit   = b;
    in_valid = 1'b1;
    eof_rx   = noise_eof && ($urandom_range(3) == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    eof_rx   = 1'b0;
  endtask

  task automatic reset_dut();
    rst      = 1'b1;
    in_valid = 1'b0;
    eof_rx   = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    e_m    = 1;
    e_ss   = 1;
    e_bw   = 0;
    e_doff = 0;
  endtask

  task automatic check_reset_outs(input string tag);
    check_val({tag, "_M"}, 32'(oindex_M), 1);
    check_val({tag, "_SS"}, 32'(oindex_SS), 1);
    check_val({tag, "_BW"}, 32'(oindex_BW), 0);
    check_val({tag, "_doff"}, 32'(oindex_data_off), 0);
    check_val({tag, "_locked"}, 32'(locked), 0);
    check_val({tag, "_sof"}, 32'(sof_rx), 0);
    check_val({tag, "_herr"}, 32'(hdr_err), 0);
    check_val({tag, "_to"}, 32'(timeout_err), 0);
  endtask

  task automatic check_index(input string tag);
    check_val({tag, "_M"}, 32'(oindex_M), 32'(e_m));
    check_val({tag, "_SS"}, 32'(oindex_SS), 32'(e_ss));
    check_val({tag, "_BW"}, 32'(oindex_BW), 32'(e_bw));
    check_val({tag, "_doff"}, 32'(oindex_data_off), 32'(e_doff));
  endtask

  task automatic send_sync(input int nflip, input int st);
    logic [31:0] w;
    logic [31:0] used;
    int          p;
    w    = SYNC;
    used = '0;
    for (int k = 0; k < nflip; k++) begin
      p = int'($urandom_range(31));
      while (used[p]) p = int'($urandom_range(31));
      used[p] = 1'b1;
      w[p]    = ~w[p];
    end
    for (int i = 31; i >= 0; i--) send_bit(w[i], st, 1'b1);
  endtask

  task automatic send_hdr(input logic [15:0] h, input int st);
    for (int i = 15; i >= 0; i--) send_bit(h[i], st, 1'b1);
  endtask

  // mode 0: eof after nb beats; 1: run into timeout; 2: eof on the timeout beat
  task automatic run_payload(input int mode, input int nb, input int st);
    int n;
    logic [31:0] s;
    s = SYNC;
    n = (mode == 0) ? nb : MAXF - 1;
    for (int i = 0; i < n; i++)
      send_bit((i < 32) ? s[31 - i] : logic'($urandom_range(1)), st, 1'b0);
    check_val("pl_locked_pre", 32'(locked), 1);
    in_bit = logic'($urandom_range(1));
    if (mode == 0) begin
      in_valid = logic'($urandom_range(1));
      eof_rx   = 1'b1;
    end else begin
      in_valid = 1'b1;
      eof_rx   = (mode == 2);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    eof_rx   = 1'b0;
    check_val("pl_to", 32'(timeout_err), (mode == 1) ? 1 : 0);
    check_val("pl_locked_post", 32'(locked), 0);
  endtask

  task automatic do_frame(input int nflip, input logic [15:0] h, input int st, input int mode, input int nb);
    int  s0, h0, t0;
    bit  ok, hit;
    s0 = sof_n;
    h0 = herr_n;
    t0 = to_n;
    hit = (nflip <= 2);
    ok  = hit && hdr_valid_ref(h);
    send_sync(nflip, st);
    send_hdr(h, st);
    if (hit) begin
      check_val("hdr_sof", 32'(sof_rx), 32'(ok));
      check_val("hdr_err", 32'(hdr_err), 32'(!ok));
      if (ok) begin
        e_m    = int'(h[15:13]);
        e_ss   = int'(h[12:9]);
        e_bw   = int'(h[8:6]);
        e_doff = int'(h[5]);
      end
      check_index("hdr_idx");
      check_val("hdr_locked", 32'(locked), 32'(ok));
      if (ok) run_payload(mode, nb, st);
    end
    idle(2);
    check_val("n_sof", 32'(sof_n - s0), 32'(ok));
    check_val("n_herr", 32'(herr_n - h0), 32'(hit && !ok));
    check_val("n_to", 32'(to_n - t0), 32'(ok && mode == 1));
    check_index("end_idx");
    if (!hit) reset_dut();
  endtask

  initial begin
    logic [15:0] h;
    logic [31:0] s;
    int s0, h0, t0;
    rst      = 1'b1;
    in_bit   = 1'b0;
    in_valid = 1'b0;
    eof_rx   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("rst");
    rst = 1'b0;

    // corrupted CRC right after reset, then a clean frame
    do_frame(0, 16'h4851, 0, 0, 5);
    check_reset_outs("badcrc");
    do_frame(0, 16'h4850, 0, 0, 10);
    check_val("clean_M", 32'(oindex_M), 2);
    check_val("clean_SS", 32'(oindex_SS), 4);
    check_val("clean_BW", 32'(oindex_BW), 1);
    check_val("clean_doff", 32'(oindex_data_off), 0);

    do_frame(2, 16'h4850, 0, 0, 3);
    do_frame(3, 16'h4850, 0, 0, 3);
    do_frame(0, 16'h4850, 40, 0, 50);
    do_frame(1, 16'h4850, 10, 1, 0);
    do_frame(0, 16'h4850, 10, 2, 0);

    // reset in the middle of a header; fill must restart from zero afterwards
    s0 = sof_n; h0 = herr_n; t0 = to_n;
    send_sync(0, 0);
    for (int i = 15; i >= 8; i--) send_bit(1'(16'h4850 >> i), 0, 1'b0);
    reset_dut();
    check_reset_outs("midhdr");
    s = SYNC;
    for (int i = 30; i >= 0; i--) send_bit(s[i], 0, 1'b0);
    for (int i = 15; i >= 0; i--) send_bit(1'(16'h4850 >> i), 0, 1'b0);
    idle(2);
    check_val("midhdr_n_sof", 32'(sof_n - s0), 0);
    check_val("midhdr_n_herr", 32'(herr_n - h0), 0);
    reset_dut();
    do_frame(0, 16'h4850, 0, 0, 4);

    // reset in the middle of a payload
    s0 = sof_n; t0 = to_n;
    send_sync(0, 0);
    send_hdr(16'h4850, 0);
    for (int i = 0; i < 60; i++) send_bit(logic'($urandom_range(1)), 0, 1'b0);
    reset_dut();
    check_reset_outs("midpl");
    idle(MAXF);
    check_val("midpl_n_sof", 32'(sof_n - s0), 1);
    check_val("midpl_n_to", 32'(to_n - t0), 0);

    for (int it = 0; it < 25; it++) begin
      if ($urandom_range(1) == 1) begin
        h[15:13] = 3'($urandom_range(1, 7));
        h[12:9]  = 4'($urandom_range(1, 15));
        h[8:5]   = 4'($urandom);
        h[4:0]   = crc5_ref(h[15:5]);
      end else begin
        h = 16'($urandom);
      end
      if (int'($urandom_range(4)) == 0) do_frame(3, 16'h4850, 0, 0, 0);
      else do_frame(int'($urandom_range(2)), h, int'($urandom_range(30)),
                    int'($urandom_range(2)), int'($urandom_range(98)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
